// File: rtl/display_scan_if.sv
// rtl/display_scan_if.sv - digit/mask inputs and scan outputs of the display scanner
//
// Purpose: carries the four frame inputs from the clock/alarm datapath and the
//          five scan outputs toward the digit decoder and display drivers.
// Signals:
//   digits[31:0]   eight BCD nibbles, digit i at [4i+3:4i], digit 0 rightmost
//   digit_en[7:0]  1 = digit i may light
//   blink_mask[7:0] 1 = digit i flashes
//   dp_mask[7:0]   1 = decimal point of digit i lit
//   x[3:0]         nibble of the current digit
//   an[7:0]        active-low anodes
//   dp             active-low decimal point
//   digit_idx[2:0] current slot index
//   scan_tick      pulse on the last cycle of each slot
// Modports: slave = scanner side, master = datapath/driver side.

interface display_scan_if;
  logic [31:0] digits;
  logic [7:0]  digit_en;
  logic [7:0]  blink_mask;
  logic [7:0]  dp_mask;
  logic [3:0]  x;
  logic [7:0]  an;
  logic        dp;
  logic [2:0]  digit_idx;
  logic        scan_tick;

  modport slave (
    input  digits, digit_en, blink_mask, dp_mask,
    output x, an, dp, digit_idx, scan_tick
  );

  modport master (
    output digits, digit_en, blink_mask, dp_mask,
    input  x, an, dp, digit_idx, scan_tick
  );
endinterface

// File: rtl/display_scan.sv
// rtl/display_scan.sv - time-multiplexed 8-digit seven-segment scanner
//
// Purpose: steps through eight digits, one slot of REFRESH_DIV cycles each,
//          blanking all anodes for the first BLANK_CYC cycles of a slot.
//          Inputs are snapshotted once per frame so a frame never tears.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   scan_if display_scan_if.slave (frame inputs in, scan outputs out)

module display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 4,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_scan_if.slave        scan_if
);

  localparam int DIV_W   = $clog2(REFRESH_DIV);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0]   BLANK_END  = DIV_W'(BLANK_CYC);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
  logic [2:0]         idx_q,       idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [31:0]        s_digits_q,  s_digits_d;
  logic [7:0]         s_en_q,      s_en_d;
  logic [7:0]         s_blink_q,   s_blink_d;
  logic [7:0]         s_dp_q,      s_dp_d;

  logic slot_end;
  logic snap_load;
  logic lit;

  always_comb begin
    slot_end  = (div_cnt_q == DIV_LAST);
    // First cycle of slot 0: also true on the first cycle after reset,
    // so a fresh snapshot is always taken before anything is lit.
    snap_load = (idx_q == 3'd0) && (div_cnt_q == '0);

    div_cnt_d     = slot_end ? '0 : div_cnt_q + DIV_W'(1);
    idx_d         = slot_end ? idx_q + 3'd1 : idx_q;

    blink_cnt_d   = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BLINK_W'(1);
    blink_phase_d = (blink_cnt_q == BLINK_LAST) ? ~blink_phase_q : blink_phase_q;

    s_digits_d = s_digits_q;
    s_en_d     = s_en_q;
    s_blink_d  = s_blink_q;
    s_dp_d     = s_dp_q;
    if (snap_load) begin
      s_digits_d = scan_if.digits;
      s_en_d     = scan_if.digit_en;
      s_blink_d  = scan_if.blink_mask;
      s_dp_d     = scan_if.dp_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      idx_q         <= 3'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      s_digits_q    <= 32'h0;
      s_en_q        <= 8'h00;
      s_blink_q     <= 8'h00;
      s_dp_q        <= 8'h00;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      s_digits_q    <= s_digits_d;
      s_en_q        <= s_en_d;
      s_blink_q     <= s_blink_d;
      s_dp_q        <= s_dp_d;
    end
  end

  // Outputs decode from registered state only. idx changes inside the blank
  // window, so x never reaches a lit anode of the wrong digit.
  always_comb begin
    lit = (div_cnt_q >= BLANK_END) && s_en_q[idx_q] &&
          !(s_blink_q[idx_q] && blink_phase_q);

    scan_if.an        = lit ? ~(8'b1 << idx_q) : 8'hFF;
    scan_if.dp        = ~(lit && s_dp_q[idx_q]);
    scan_if.x         = s_digits_q[{idx_q, 2'b00} +: 4];
    scan_if.digit_idx = idx_q;
    scan_if.scan_tick = slot_end;
  end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed scanner for the 8-digit seven-segment display. It takes eight BCD digits from the clock/alarm datapath and steps through them one at a time. For each step it drives the single-digit nibble `x` into the downstream combinational digit decoder, which produces the active-low `seg[6:0]`. It also drives the active-low anodes, decimal point, per-digit enable and blink masking, and an anti-ghosting blank interval.

## Interface
Parameters:
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz). Must be greater than `BLANK_CYC`.
- `BLANK_CYC`, 4: cycles at the start of each slot during which all anodes are off. Must be at least 1.
- `BLINK_DIV`, 50000000: cycles between `blink_phase` toggles (1 Hz flash at 100 MHz).

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `digits` in 32: eight BCD nibbles. Digit i is at `[4i+3:4i]`; digit 0 is the rightmost.
- `digit_en` in 8: 1 means digit i may light.
- `blink_mask` in 8: 1 means digit i flashes, for alarm-set mode.
- `dp_mask` in 8: 1 means the decimal point of digit i is lit.
- `x` out 4: nibble of the current digit, fed to the digit decoder.
- `an` out 8: anodes, active-low, at most one bit low.
- `dp` out 1: decimal point, active-low.
- `digit_idx` out 3: index of the current slot.
- `scan_tick` out 1: one-cycle pulse on the last cycle of each slot.

## Operation
- State: `div_cnt` (0..`REFRESH_DIV`-1), `idx` (3 bits), `blink_cnt` (0..`BLINK_DIV`-1), `blink_phase`, and a snapshot register set `s_digits`, `s_en`, `s_blink`, `s_dp`.
- Slot counter:
  - `div_cnt` increments every cycle.
  - At `REFRESH_DIV`-1 it wraps to 0 and `idx` increments, wrapping 7 to 0 with natural 3-bit overflow.
- Snapshot:
  - All four inputs are loaded into the snapshot on the clock edge that ends a cycle in which `idx`==0 and `div_cnt`==0. This is the first cycle of slot 0.
  - This gives tear-free frames. Input changes mid-frame are ignored until the next frame.
  - The first load happens on the first edge after reset release.
- Blink: `blink_cnt` wraps at `BLINK_DIV`-1 and toggles `blink_phase` on the wrap. `blink_phase`=1 means blinked digits are dark.
- `x` = `s_digits[4*idx +: 4]`. It is passed through unmodified, including non-BCD values 0xA to 0xF.
- `an[idx]` = 0 only when all three hold: `div_cnt` ≥ `BLANK_CYC`, `s_en[idx]`=1, and NOT (`s_blink[idx]` AND `blink_phase`). All other `an` bits are always 1.
- `dp` = NOT (`s_dp[idx]` AND `an[idx]`==0). The decimal point is never lit while the digit is dark.
- `digit_idx` = `idx`.
- `scan_tick` = (`div_cnt` == `REFRESH_DIV`-1).
- All outputs decode from registered state only. There is no combinational path from any input to any output.

## Timing
- Reset values:
  - Counters, `idx`, `blink_phase`, and all snapshot bits are 0.
  - Therefore `an`=8'hFF, `x`=4'h0, `dp`=1, `digit_idx`=0, `scan_tick`=0.
- Slot k occupies `REFRESH_DIV` cycles:
  - Cycles 0..`BLANK_CYC`-1: `an`=8'hFF.
  - Cycles `BLANK_CYC`..`REFRESH_DIV`-1: the digit is lit if enabled.
- `x` and `digit_idx` change on the same edge as `idx`, which falls inside the blank interval. No segment data is ever shown on the wrong anode.
- Full frame: 8×`REFRESH_DIV` cycles.
- Input to display latency: up to one frame plus `BLANK_CYC` cycles.
- Mid-frame input changes: not visible until the frame after the next snapshot.
- Blink boundaries:
  - A `blink_phase` toggle mid-slot takes effect on the next cycle.
  - A digit that blinks off mid-slot goes dark immediately.
- Reset asserted mid-operation: all outputs take their reset values asynchronously. After release, scanning restarts at slot 0 with a fresh snapshot.
- `digit_en`=0: all anodes stay high indefinitely and the counters still run.

## Test plan
All scenarios use `REFRESH_DIV`=8, `BLANK_CYC`=2, `BLINK_DIV`=64.
- **Reset:** hold `rst_n`=0 for 5 cycles with arbitrary inputs → `an`=FF, `dp`=1, `x`=0, `scan_tick`=0. Release → the first `an`=FE appears at cycle 2 with `x`=`digits[3:0]`.
- **Scan order:** `digits`=32'h76543210, `digit_en`=FF → `an` steps FE, FD, FB … 7F with `x`=0..7. Each digit is lit for 6 cycles after 2 cycles of FF. `scan_tick` pulses every 8 cycles. Frame is 64 cycles.
- **Tear-free snapshot:** change `digits` to 32'h99999999 at cycle 20 → the remainder of frame 0 still shows the old values. Frame 1 shows 9 on every digit.
- **Enable and decimal point:** `digit_en`=8'h0F, `dp_mask`=8'h04 → digits 4..7 stay dark. `dp`=0 only while `an`=FB and lit; otherwise `dp`=1.
- **Blink:** `blink_mask`=8'h30 → digits 4 and 5 are lit for cycles 0..63. They are dark for 64..127 while digits 0..3 continue. The pattern repeats with a 128-cycle period.
- **Mid-operation reset:** assert `rst_n`=0 during slot 5 → `an`=FF immediately, asynchronously. After release, `digit_idx` restarts at 0 and the snapshot reloads.
